axis_decimator_v1_0: RTL
========================

# axis_decimator_v1_0

Downstream stage of the serial FIR: consumes the filtered AXI-Stream samples and reduces the sample rate by a run-time power-of-two ratio 2^L (L = 0..8). Two modes: pick (forward the last sample of each group) and average (boxcar mean of the group, the usual anti-alias companion to the FIR). A single output register with AXI-Stream backpressure feeds the next stage (DAC or DMA interface).

## Interface
- inout_width, 16: sample width, signed two's complement, same Q format in and out
- max_log2_ratio, 8: largest supported L; accumulator width = inout_width + max_log2_ratio
- aclk  in  1  clock, all logic on rising edge
- resetn  in  1  reset, synchronous, active-low
- s_axis_tdata  in  inout_width  input sample
- s_axis_tlast  in  1  input frame marker
- s_axis_tvalid  in  1  input sample valid
- s_axis_tready  out  1  block can accept a sample
- m_axis_tdata  out  inout_width  decimated sample
- m_axis_tlast  out  1  output frame marker
- m_axis_tvalid  out  1  output sample valid
- m_axis_tready  in  1  downstream accepts
- log2_ratio  in  4  L; values above max_log2_ratio are clamped to max_log2_ratio
- mode  in  1  0 = pick, 1 = average

## Operation
- Input beat accepted when s_axis_tvalid && s_axis_tready; output beat transferred when m_axis_tvalid && m_axis_tready.
- Group state: count (max_log2_ratio+1 bits), acc (signed, inout_width+max_log2_ratio bits), last_flag, latched L_q and mode_q.
- States: IDLE (count == 0), ACCUM (0 < count < 2^L_q). Accepted beat in IDLE latches log2_ratio (clamped) and mode into L_q/mode_q; config changes mid-group are ignored until the next group.
- Each accepted beat: acc <= (IDLE ? 0 : acc) + sign-extended sample; last_flag <= (IDLE ? 0 : last_flag) | s_axis_tlast; count increments.
- Group completes on the beat that makes count == 2^L_q: count <= 0 (back to IDLE), and the output register loads:
  - pick: tdata = that beat's sample
  - average: tdata = (acc + sample) >>> L_q, arithmetic shift (floor toward -inf), low inout_width bits; no overflow possible
  - m_axis_tlast = last_flag | s_axis_tlast of the completing beat
- L = 0: every accepted beat completes a group; both modes pass data through unchanged.
- tlast does not terminate a group early; it is sticky-ORed into the group's output.
- Output register: m_axis_tvalid set on group completion, cleared on transfer unless a new group completes in the same cycle (then stays 1 with new data).
- s_axis_tready = !m_axis_tvalid || m_axis_tready (combinational). Beats that do not complete a group are still gated by this rule.

## Timing
- Reset values: m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 0, count 0, acc 0, last_flag 0, L_q 0, mode_q 0; s_axis_tready therefore 1 after reset.
- Latency: m_axis_tvalid asserted the cycle after the completing input beat is accepted.
- Throughput: one input beat per cycle with m_axis_tready held high; no bubbles at group boundaries.
- Backpressure: with m_axis_tvalid high and m_axis_tready low, s_axis_tready is 0 and m_axis_tdata/tlast hold stable.
- Reset asserted mid-group or with output pending: group and output discarded, all state to reset values on the next edge.

## Structure
- Shared package: state encoding (IDLE/ACCUM as count==0 test, no separate enum needed), mode constants MODE_PICK = 0, MODE_AVG = 1, clamp helper for L.
- One natural sub-module: axis_output_reg (data+tlast holding register with valid/ready), reusable by other stream blocks.
- Remainder (counter, accumulator, config latch) lives in the top module; target 150-250 lines.

## Test plan
- Pick, L=2, tready=1, inputs 1,2,3,4,5,6,7,8 -> outputs 4, 8; each valid one cycle after beats 4 and 8.
- Average, L=2, inputs 10,20,30,41 -> output 25 (101>>>2); inputs -1,-1,-1,-2 -> output -2 (floor).
- Average, L=8, 256 beats of 0x7FFF then 256 of 0x8000 -> outputs 0x7FFF, 0x8000 (no accumulator overflow).
- L=0, mode either, tready=1 streaming 0..9 -> same values out, one-cycle latency, s_axis_tready never drops.
- Backpressure: L=1, m_axis_tready low after first output -> s_axis_tready 0, output data stable; release -> transfer, stream resumes with no lost or duplicated samples.
- tlast on beat 2 of a 4-beat group, log2_ratio changed 2->1 on beat 3, resetn pulsed mid-next-group -> group output has tlast=1 and ratio 4 kept; after reset m_axis_tvalid=0, tready=1, next group uses new ratio.

Source files
------------

// File: rtl/axis_decimator_v1_0_pkg.sv
// Shared definitions for the AXI-Stream decimator: mode encoding and ratio clamp.
// Group state is encoded by the sample counter (count == 0 means IDLE).
package axis_decimator_v1_0_pkg;

  localparam logic MODE_PICK = 1'b0;
  localparam logic MODE_AVG  = 1'b1;

  // Saturate a requested log2 ratio to the largest supported value.
  function automatic logic [3:0] clamp_log2_ratio(input logic [3:0] l_req,
                                                  input logic [3:0] l_max);
    return (l_req > l_max) ? l_max : l_req;
  endfunction

endpackage

// File: rtl/axis_output_reg.sv
// Single-entry AXI-Stream holding register (data + tlast) with valid/ready.
// can_load tells the producer a new beat may be loaded this cycle.
module axis_output_reg #(
  parameter int data_width = 16
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [data_width-1:0] load_data,
  input  logic                  load_last,
  output logic                  can_load,
  output logic [data_width-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  assign can_load = !m_axis_tvalid || m_axis_tready;

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (load) begin
      // A load in the same cycle as a transfer replaces the departing beat.
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= load_data;
      m_axis_tlast  <= load_last;
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_decimator_v1_0.sv
// Power-of-two sample-rate decimator (pick or boxcar average) on AXI-Stream.
//   state | meaning
//   IDLE  | count == 0; next accepted beat opens a group and latches ratio/mode
//   ACCUM | 0 < count < 2^l_q; beats summed into acc, tlast ORed into last_flag
module axis_decimator_v1_0
  import axis_decimator_v1_0_pkg::*;
#(
  parameter int inout_width    = 16,
  parameter int max_log2_ratio = 8
) (
  input  logic                   aclk,
  input  logic                   resetn,
  input  logic [inout_width-1:0] s_axis_tdata,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [inout_width-1:0] m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  input  logic [3:0]             log2_ratio,
  input  logic                   mode
);

  localparam int acc_width = inout_width + max_log2_ratio;
  localparam int cnt_width = max_log2_ratio + 1;

  logic [cnt_width-1:0]        count;
  logic signed [acc_width-1:0] acc;
  logic                        last_flag;
  logic [3:0]                  l_q;
  logic                        mode_q;

  logic                        idle;
  logic                        accept;
  logic                        complete;
  logic [3:0]                  l_eff;
  logic                        mode_eff;
  logic [cnt_width-1:0]        group_size;
  logic [cnt_width-1:0]        count_inc;
  logic signed [acc_width-1:0] sample_ext;
  logic signed [acc_width-1:0] acc_sum;
  logic [inout_width-1:0]      avg_data;
  logic [inout_width-1:0]      group_data;
  logic                        last_any;

  assign idle   = (count == '0);
  assign accept = s_axis_tvalid && s_axis_tready;

  // The completing beat of a 1-beat group is also its opening beat, so the
  // effective config must come straight from the inputs while idle.
  always_comb begin
    l_eff      = idle ? clamp_log2_ratio(log2_ratio, 4'(max_log2_ratio)) : l_q;
    mode_eff   = idle ? mode : mode_q;
    group_size = cnt_width'(1) << l_eff;
    count_inc  = count + cnt_width'(1);
    sample_ext = {{max_log2_ratio{s_axis_tdata[inout_width-1]}}, s_axis_tdata};
    acc_sum    = (idle ? '0 : acc) + sample_ext;
    avg_data   = inout_width'(acc_sum >>> l_eff);
    last_any   = (!idle && last_flag) || s_axis_tlast;
    group_data = (mode_eff == MODE_AVG) ? avg_data : s_axis_tdata;
    complete   = accept && (count_inc == group_size);
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      count     <= '0;
      acc       <= '0;
      last_flag <= 1'b0;
      l_q       <= '0;
      mode_q    <= MODE_PICK;
    end else if (accept) begin
      count     <= complete ? '0 : count_inc;
      acc       <= acc_sum;
      last_flag <= last_any;
      if (idle) begin
        l_q    <= l_eff;
        mode_q <= mode_eff;
      end
    end
  end

  axis_output_reg #(
    .data_width (inout_width)
  ) u_out_reg (
    .aclk          (aclk),
    .resetn        (resetn),
    .load          (complete),
    .load_data     (group_data),
    .load_last     (last_any),
    .can_load      (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

endmodule
